// File: rtl/noc_port_requester.sv
// ---------------------------------------------------------------------------
// noc_port_requester
//
// Purpose:
//   Request generator for one input port of a 5-port (L/N/E/W/S) NoC router.
//   It watches the port input buffer and decodes the header flit. It then
//   holds a request to the arbiter for the whole packet. Flits are forwarded
//   to the crossbar only while the arbiter grants this port. If the arbiter
//   revokes the grant (timeout or preemption), the port re-arbitrates and
//   resumes the packet from the next flit.
//
// Parameters:
//   DATA_W  flit payload width
//   LEN_W   header length field width (must be smaller than DATA_W)
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   in_valid     input buffer holds a flit
//   in_flit      flit data; a header carries the packet length in [LEN_W-1:0]
//   in_flit_id   flit type: 001 header, 010 body, 100 tail
//   in_ready     flit is popped from the buffer this cycle
//   grant        arbiter grant for this port (registered in the arbiter)
//   req          request to the arbiter (registered)
//   flit_id      flit type presented to the arbiter timer (registered)
//   length       latched header length for the arbiter timer (registered)
//   out_valid    flit forwarded to the crossbar this cycle
//   out_flit     forwarded flit data
//   out_flit_id  forwarded flit type
//   err_drop     one-cycle pulse: a non-header flit was discarded while idle
//   err_len      one-cycle pulse: the tail count disagrees with the header
//                length, or an extra header appeared mid-packet
// ---------------------------------------------------------------------------
module noc_port_requester #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_flit,
   input  logic [2:0]        in_flit_id,
   output logic              in_ready,
   input  logic              grant,
   output logic              req,
   output logic [2:0]        flit_id,
   output logic [LEN_W-1:0]  length,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_flit,
   output logic [2:0]        out_flit_id,
   output logic              err_drop,
   output logic              err_len
);

   localparam logic [2:0] ID_NONE = 3'b000;
   localparam logic [2:0] ID_HEAD = 3'b001;
   localparam logic [2:0] ID_BODY = 3'b010;
   localparam logic [2:0] ID_TAIL = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic             hdr_sent;
   logic             is_header;
   logic             is_tail;
   logic             xfer;
   logic             drop;

   // Decode the incoming flit type. Any value other than the exact header code
   // (including non-one-hot codes) counts as a non-header.
   assign is_header = (in_flit_id == ID_HEAD);
   assign is_tail   = (in_flit_id == ID_TAIL);

   // A flit moves to the crossbar only while sending, granted and valid.
   // While idle, stray non-header flits are popped and discarded. The header
   // itself stays in the buffer until the grant arrives, so it becomes the
   // first flit on the link. Nothing is popped while reset is held.
   assign xfer        = (state == SEND) && in_valid && grant && !rst;
   assign drop        = (state == IDLE) && in_valid && !is_header && !rst;
   assign in_ready    = xfer || drop;
   assign out_valid   = xfer;
   assign out_flit    = in_flit;
   assign out_flit_id = in_flit_id;

   // Packet FSM with registered arbiter-side outputs.
   // - remaining counts flits still expected, including the header. A
   //   well-formed packet therefore accepts its tail with exactly one left.
   // - hdr_sent separates the packet's own header, which is the first flit
   //   sent, from a second header that shows up in the middle of a packet.
   //   That second header is forwarded as body and flagged.
   // - On grant loss, flit_id returns to the header code so that the arbiter
   //   timer reloads length when this port is granted again.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req       <= 1'b0;
         flit_id   <= ID_NONE;
         length    <= '0;
         remaining <= '0;
         hdr_sent  <= 1'b0;
         err_drop  <= 1'b0;
         err_len   <= 1'b0;
      end else begin
         err_drop <= 1'b0;
         err_len  <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_header) begin
                     length    <= in_flit[LEN_W-1:0];
                     remaining <= in_flit[LEN_W-1:0];
                     hdr_sent  <= 1'b0;
                     req       <= 1'b1;
                     flit_id   <= ID_HEAD;
                     state     <= REQ;
                  end else begin
                     err_drop <= 1'b1;
                  end
               end
            end

            REQ: begin
               if (grant) begin
                  state <= SEND;
               end
            end

            SEND: begin
               if (xfer) begin
                  remaining <= (remaining != '0) ? remaining - LEN_W'(1) : '0;
                  hdr_sent  <= 1'b1;
                  if (is_tail) begin
                     flit_id <= ID_TAIL;
                     req     <= 1'b0;
                     err_len <= (remaining != LEN_W'(1));
                     state   <= IDLE;
                  end else if (is_header && hdr_sent) begin
                     flit_id <= ID_BODY;
                     err_len <= 1'b1;
                  end else begin
                     flit_id <= in_flit_id;
                  end
               end else if (!grant) begin
                  flit_id <= ID_HEAD;
                  state   <= REQ;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_noc_port_requester.sv
// ---------------------------------------------------------------------------
// tb_noc_port_requester
//
// Directed testbench for noc_port_requester. The initial block drives inputs
// one cycle at a time, 1 ns after each rising edge. It checks registered
// outputs, and combinational outputs after they settle, well away from the
// next edge. Expected values come from the packet sequence itself: header
// lengths, flit order and grant timing.
// ---------------------------------------------------------------------------
module tb_noc_port_requester;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 12;

   localparam logic [2:0] HEAD = 3'b001;
   localparam logic [2:0] BODY = 3'b010;
   localparam logic [2:0] TAIL = 3'b100;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic [DATA_W-1:0] in_flit;
   logic [2:0]        in_flit_id;
   logic              in_ready;
   logic              grant;
   logic              req;
   logic [2:0]        flit_id;
   logic [LEN_W-1:0]  length;
   logic              out_valid;
   logic [DATA_W-1:0] out_flit;
   logic [2:0]        out_flit_id;
   logic              err_drop;
   logic              err_len;

   int testCount;
   int failCount;

   noc_port_requester #(
      .DATA_W(DATA_W),
      .LEN_W (LEN_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_flit    (in_flit),
      .in_flit_id (in_flit_id),
      .in_ready   (in_ready),
      .grant      (grant),
      .req        (req),
      .flit_id    (flit_id),
      .length     (length),
      .out_valid  (out_valid),
      .out_flit   (out_flit),
      .out_flit_id(out_flit_id),
      .err_drop   (err_drop),
      .err_len    (err_len)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 ns past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the buffer and grant inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic [31:0] f,
                                input logic [2:0] id, input logic g);
      in_valid   = v;
      in_flit    = f;
      in_flit_id = id;
      grant      = g;
      #1;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present a header, grant it one cycle after req rises, and check that the
   // header is forwarded. The task returns with the header accepted.
   task automatic startPacket(input string tag, input logic [31:0] hdr);
      applyStimulus(1'b1, hdr, HEAD, 1'b0);
      tick();
      checkOutput({tag, "_req"}, 32'(req), 32'd1);
      applyStimulus(1'b1, hdr, HEAD, 1'b1);
      checkOutput({tag, "_req_state_no_fwd"}, 32'(out_valid), 32'd0);
      tick();
      applyStimulus(1'b1, hdr, HEAD, 1'b1);
      checkOutput({tag, "_hdr_fwd"}, 32'(out_valid), 32'd1);
      tick();
   endtask

   initial begin
      testCount  = 0;
      failCount  = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_flit    = '0;
      in_flit_id = 3'b000;
      grant      = 1'b0;

      // ---------------- reset state ----------------
      applyStimulus(1'b1, 32'h0000_0055, BODY, 1'b0);
      checkOutput("rst_no_pop", 32'(in_ready), 32'd0);
      tick();
      tick();
      checkOutput("rst_req", 32'(req), 32'd0);
      checkOutput("rst_flit_id", 32'(flit_id), 32'd0);
      checkOutput("rst_length", 32'(length), 32'd0);
      checkOutput("rst_err_drop", 32'(err_drop), 32'd0);
      checkOutput("rst_err_len", 32'(err_len), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
      tick();

      // ---------------- T1: len=3 packet ----------------
      applyStimulus(1'b1, 32'hABCD_E003, HEAD, 1'b0);
      checkOutput("t1_hdr_not_popped", 32'(in_ready), 32'd0);
      checkOutput("t1_req_before", 32'(req), 32'd0);
      tick();
      checkOutput("t1_req", 32'(req), 32'd1);
      checkOutput("t1_flit_id_hdr", 32'(flit_id), 32'(HEAD));
      checkOutput("t1_length", 32'(length), 32'd3);
      applyStimulus(1'b1, 32'hABCD_E003, HEAD, 1'b0);
      checkOutput("t1_no_fwd_ungranted", 32'(out_valid), 32'd0);
      tick();
      applyStimulus(1'b1, 32'hABCD_E003, HEAD, 1'b1);
      checkOutput("t1_no_fwd_req_state", 32'(out_valid), 32'd0);
      tick();
      applyStimulus(1'b1, 32'hABCD_E003, HEAD, 1'b1);
      checkOutput("t1_fwd0_valid", 32'(out_valid), 32'd1);
      checkOutput("t1_fwd0_ready", 32'(in_ready), 32'd1);
      checkOutput("t1_fwd0_id", 32'(out_flit_id), 32'(HEAD));
      checkOutput("t1_fwd0_data", out_flit, 32'hABCD_E003);
      tick();
      checkOutput("t1_flit_id_after_hdr", 32'(flit_id), 32'(HEAD));
      applyStimulus(1'b1, 32'h1111_1111, BODY, 1'b1);
      checkOutput("t1_fwd1_valid", 32'(out_valid), 32'd1);
      checkOutput("t1_fwd1_id", 32'(out_flit_id), 32'(BODY));
      tick();
      checkOutput("t1_flit_id_body", 32'(flit_id), 32'(BODY));
      applyStimulus(1'b1, 32'h2222_2222, TAIL, 1'b1);
      checkOutput("t1_fwd2_valid", 32'(out_valid), 32'd1);
      checkOutput("t1_fwd2_id", 32'(out_flit_id), 32'(TAIL));
      tick();
      checkOutput("t1_req_drop", 32'(req), 32'd0);
      checkOutput("t1_err_len", 32'(err_len), 32'd0);
      checkOutput("t1_flit_id_tail", 32'(flit_id), 32'(TAIL));
      applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
      checkOutput("t1_idle_no_fwd", 32'(out_valid), 32'd0);
      tick();

      // ---------------- T2: stray body in IDLE ----------------
      applyStimulus(1'b1, 32'h0000_3333, BODY, 1'b0);
      checkOutput("t2_pop", 32'(in_ready), 32'd1);
      checkOutput("t2_no_fwd", 32'(out_valid), 32'd0);
      tick();
      checkOutput("t2_err_drop", 32'(err_drop), 32'd1);
      checkOutput("t2_req", 32'(req), 32'd0);
      applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
      checkOutput("t2_no_pop", 32'(in_ready), 32'd0);
      tick();
      checkOutput("t2_err_drop_clear", 32'(err_drop), 32'd0);

      // ---------------- T3: len=5 with grant loss ----------------
      startPacket("t3", 32'hABCD_E005);
      applyStimulus(1'b1, 32'h5555_0001, BODY, 1'b1);
      checkOutput("t3_fwd_b1", 32'(out_valid), 32'd1);
      tick();
      applyStimulus(1'b1, 32'h5555_0002, BODY, 1'b0);
      checkOutput("t3_loss_no_fwd", 32'(out_valid), 32'd0);
      checkOutput("t3_loss_no_pop", 32'(in_ready), 32'd0);
      tick();
      checkOutput("t3_flit_id_reload", 32'(flit_id), 32'(HEAD));
      checkOutput("t3_req_held", 32'(req), 32'd1);
      checkOutput("t3_length", 32'(length), 32'd5);
      applyStimulus(1'b1, 32'h5555_0002, BODY, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h5555_0002, BODY, 1'b1);
      checkOutput("t3_regrant_req_state", 32'(out_valid), 32'd0);
      tick();
      applyStimulus(1'b1, 32'h5555_0002, BODY, 1'b1);
      checkOutput("t3_fwd_b2", 32'(out_valid), 32'd1);
      checkOutput("t3_fwd_b2_data", out_flit, 32'h5555_0002);
      tick();
      applyStimulus(1'b1, 32'h5555_0003, BODY, 1'b1);
      checkOutput("t3_fwd_b3", 32'(out_valid), 32'd1);
      tick();
      applyStimulus(1'b1, 32'h5555_00FF, TAIL, 1'b1);
      checkOutput("t3_fwd_tail", 32'(out_valid), 32'd1);
      tick();
      checkOutput("t3_req_drop", 32'(req), 32'd0);
      checkOutput("t3_err_len", 32'(err_len), 32'd0);
      applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
      tick();

      // ---------------- T4: len=4, tail as 2nd flit ----------------
      startPacket("t4", 32'hABCD_E004);
      applyStimulus(1'b1, 32'h4444_00FF, TAIL, 1'b1);
      checkOutput("t4_fwd_tail", 32'(out_valid), 32'd1);
      tick();
      checkOutput("t4_err_len", 32'(err_len), 32'd1);
      checkOutput("t4_req_drop", 32'(req), 32'd0);
      applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
      checkOutput("t4_idle_no_pop", 32'(in_ready), 32'd0);
      tick();
      checkOutput("t4_err_len_pulse", 32'(err_len), 32'd0);

      // ---------------- T5: in_valid toggling in SEND ----------------
      startPacket("t5", 32'hABCD_E003);
      applyStimulus(1'b0, 32'h0, BODY, 1'b1);
      checkOutput("t5_gap1", 32'(out_valid), 32'd0);
      checkOutput("t5_gap1_ready", 32'(in_ready), 32'd0);
      tick();
      applyStimulus(1'b1, 32'h7777_0001, BODY, 1'b1);
      checkOutput("t5_fwd_b", 32'(out_valid), 32'd1);
      tick();
      applyStimulus(1'b0, 32'h0, TAIL, 1'b1);
      checkOutput("t5_gap2", 32'(out_valid), 32'd0);
      tick();
      applyStimulus(1'b1, 32'h7777_00FF, TAIL, 1'b1);
      checkOutput("t5_fwd_tail", 32'(out_valid), 32'd1);
      tick();
      checkOutput("t5_err_len", 32'(err_len), 32'd0);
      checkOutput("t5_req_drop", 32'(req), 32'd0);
      applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
      tick();

      // ---------------- T6: reset mid-SEND, then restart ----------------
      startPacket("t6", 32'hABCD_E007);
      applyStimulus(1'b1, 32'h6666_0001, BODY, 1'b1);
      tick();
      rst = 1'b1;
      applyStimulus(1'b1, 32'h6666_0002, BODY, 1'b1);
      checkOutput("t6_rst_no_pop", 32'(in_ready), 32'd0);
      checkOutput("t6_rst_no_fwd", 32'(out_valid), 32'd0);
      tick();
      checkOutput("t6_req", 32'(req), 32'd0);
      checkOutput("t6_length", 32'(length), 32'd0);
      checkOutput("t6_flit_id", 32'(flit_id), 32'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
      checkOutput("t6_in_ready", 32'(in_ready), 32'd0);
      tick();
      startPacket("t6r", 32'hABCD_E002);
      checkOutput("t6r_length", 32'(length), 32'd2);
      applyStimulus(1'b1, 32'h6666_00FF, TAIL, 1'b1);
      checkOutput("t6r_fwd_tail", 32'(out_valid), 32'd1);
      tick();
      checkOutput("t6r_err_len", 32'(err_len), 32'd0);
      checkOutput("t6r_req_drop", 32'(req), 32'd0);
      applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
      tick();

      // ---------------- T7: length=0 header ----------------
      startPacket("t7", 32'hABCD_E000);
      applyStimulus(1'b1, 32'h0000_00FF, TAIL, 1'b1);
      checkOutput("t7_fwd_tail", 32'(out_valid), 32'd1);
      tick();
      checkOutput("t7_err_len", 32'(err_len), 32'd1);
      checkOutput("t7_req_drop", 32'(req), 32'd0);
      applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
      tick();

      // ---------------- T8: extra header inside a packet ----------------
      startPacket("t8", 32'hABCD_E003);
      applyStimulus(1'b1, 32'hABCD_E009, HEAD, 1'b1);
      checkOutput("t8_fwd_extra_hdr", 32'(out_valid), 32'd1);
      tick();
      checkOutput("t8_err_len", 32'(err_len), 32'd1);
      checkOutput("t8_flit_id_body", 32'(flit_id), 32'(BODY));
      checkOutput("t8_length_kept", 32'(length), 32'd3);
      applyStimulus(1'b1, 32'h8888_00FF, TAIL, 1'b1);
      checkOutput("t8_fwd_tail", 32'(out_valid), 32'd1);
      tick();
      checkOutput("t8_tail_err_len", 32'(err_len), 32'd0);
      checkOutput("t8_req_drop", 32'(req), 32'd0);
      applyStimulus(1'b0, 32'h0, 3'b000, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
